// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: FSM states, default cycle
// budget and the end-of-run report record.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  localparam int unsigned CYCLES_W  = 32;
  localparam int unsigned RET_W     = 8;
  localparam int unsigned TIMEOUT_W = 1;

  localparam logic [CYCLES_W-1:0] DEFAULT_MAX_CYCLES = 32'd500000;

  typedef struct packed {
    logic [CYCLES_W-1:0]  cycles;
    logic [RET_W-1:0]     ret;
    logic [TIMEOUT_W-1:0] timeout;
  } report_t;

  // The CPU clock is enabled only in the two executing states.
  function automatic logic is_enabled_state(input run_state_e st);
    return (st == ST_RUN) || (st == ST_STEP);
  endfunction

  function automatic report_t make_report(input logic [CYCLES_W-1:0]  cycles,
                                          input logic [RET_W-1:0]     ret,
                                          input logic [TIMEOUT_W-1:0] timeout);
    report_t r;
    r.cycles  = cycles;
    r.ret     = ret;
    r.timeout = timeout;
    return r;
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Control/report bundle between a run controller and its host.
interface run_ctrl_if;
  import run_ctrl_pkg::*;

  logic                start;
  logic                stop;
  logic                step;
  logic                isHalt;
  logic [15:0]         ret_val;
  logic                cpu_en;
  logic [CYCLES_W-1:0] cycle_count;
  logic                rpt_valid;
  logic                rpt_ready;
  logic [CYCLES_W-1:0] rpt_cycles;
  logic [RET_W-1:0]    rpt_ret;
  logic                rpt_timeout;

  // Host side: issues run commands and consumes the report.
  modport master (
    output start, stop, step, isHalt, ret_val, rpt_ready,
    input  cpu_en, cycle_count, rpt_valid, rpt_cycles, rpt_ret, rpt_timeout
  );

  // Controller side.
  modport slave (
    input  start, stop, step, isHalt, ret_val, rpt_ready,
    output cpu_en, cycle_count, rpt_valid, rpt_cycles, rpt_ret, rpt_timeout
  );
endinterface

// File: rtl/run_cycle_ctr.sv
// Enabled-cycle counter with synchronous clear and a compare against the
// run budget.
module run_cycle_ctr
  import run_ctrl_pkg::*;
#(
  parameter logic [CYCLES_W-1:0] LIMIT = DEFAULT_MAX_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  output logic [CYCLES_W-1:0] count,
  output logic                at_limit
);

  logic [CYCLES_W-1:0] count_r;

  // Count enabled cycles; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + CYCLES_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count    = count_r;
  assign at_limit = (count_r == LIMIT);

endmodule

// File: rtl/run_ctrl.sv
// Run controller: gates the CPU clock for free-running or single-step
// execution, enforces a cycle budget and hands an end-of-run report to the
// host over a valid/ready handshake.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter logic [CYCLES_W-1:0] MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
  input logic       clk,
  input logic       rst_n,
  run_ctrl_if.slave bus
);

  run_state_e          state_r;
  run_state_e          state_s;
  logic                cpu_en_r;
  logic                step_armed_r;
  logic                step_armed_s;
  logic                step_take_s;
  logic                halt_s;
  logic                timeout_s;
  logic                accept_s;
  logic                ctr_en_s;
  logic                at_limit_s;
  logic [CYCLES_W-1:0] count_s;
  report_t             rpt_r;
  logic                rpt_valid_r;

  // Halt is only meaningful while the CPU is clocked, and beats the budget.
  assign halt_s    = cpu_en_r & bus.isHalt;
  assign timeout_s = cpu_en_r & at_limit_s & ~bus.isHalt;
  // The timeout edge itself is not counted.
  assign ctr_en_s  = cpu_en_r & ~timeout_s;
  assign accept_s  = (state_r == ST_DONE) & rpt_valid_r & bus.rpt_ready;

  run_cycle_ctr #(
    .LIMIT (MAX_CYCLES)
  ) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ctr_en_s),
    .clr      (accept_s),
    .count    (count_s),
    .at_limit (at_limit_s)
  );

  // Next-state decode; end-of-run conditions outrank stop.
  always_comb begin
    state_s     = state_r;
    step_take_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_s = ST_RUN;
        end else if (bus.step && step_armed_r) begin
          state_s     = ST_STEP;
          step_take_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_s || timeout_s) begin
          state_s = ST_DONE;
        end else if (bus.stop) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STEP: begin
        if (halt_s || timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (accept_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // A step request re-arms only after step has been observed low.
  always_comb begin
    step_armed_s = step_armed_r;
    if (!bus.step) begin
      step_armed_s = 1'b1;
    end else if (step_take_s) begin
      step_armed_s = 1'b0;
    end else begin
      step_armed_s = step_armed_r;
    end
  end

  // State register; cpu_en is registered from the next state so it tracks
  // RUN/STEP exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cpu_en_r     <= 1'b0;
      step_armed_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      cpu_en_r     <= is_enabled_state(state_s);
      step_armed_r <= step_armed_s;
    end
  end

  // Capture the report at the end-of-run edge and hold it until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_r       <= '0;
      rpt_valid_r <= 1'b0;
    end else if (halt_s) begin
      rpt_r       <= make_report(count_s + CYCLES_W'(1), bus.ret_val[RET_W-1:0], 1'b0);
      rpt_valid_r <= 1'b1;
    end else if (timeout_s) begin
      rpt_r       <= make_report(count_s, 8'd0, 1'b1);
      rpt_valid_r <= 1'b1;
    end else if (accept_s) begin
      rpt_r       <= rpt_r;
      rpt_valid_r <= 1'b0;
    end else begin
      rpt_r       <= rpt_r;
      rpt_valid_r <= rpt_valid_r;
    end
  end

  assign bus.cpu_en      = cpu_en_r;
  assign bus.cycle_count = count_s;
  assign bus.rpt_valid   = rpt_valid_r;
  assign bus.rpt_cycles  = rpt_r.cycles;
  assign bus.rpt_ret     = rpt_r.ret;
  assign bus.rpt_timeout = rpt_r.timeout[0];

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 500000: cycle budget per run before forced timeout; legal range 1..2^32-1.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: level; begin or resume free-running execution.
REQ-005 SHALL have port stop, input, 1: level; pause execution.
REQ-006 SHALL have port step, input, 1: level; execute exactly one CPU cycle from pause.
REQ-007 SHALL have port isHalt, input, 1: CPU halt indication, meaningful only while cpu_en=1.
REQ-008 SHALL have port ret_val, input, 16: CPU return register.
REQ-009 SHALL have port cpu_en, output, 1: CPU clock-enable; CPU advances on every edge where cpu_en=1.
REQ-010 SHALL have port cycle_count, output, 32: enabled cycles in the current run.
REQ-011 SHALL have port rpt_valid, output, 1: end-of-run report valid.
REQ-012 SHALL have port rpt_ready, input, 1: consumer accepts the report.
REQ-013 SHALL have port rpt_cycles, output, 32: final cycle count.
REQ-014 SHALL have port rpt_ret, output, 8: ret_val[7:0] captured at halt.
REQ-015 SHALL have port rpt_timeout, output, 1: 1 = run ended by budget, 0 = ended by isHalt.

Function
REQ-016 SHALL implement states IDLE, RUN, STEP, DONE; cpu_en is registered and equals 1 exactly while state is RUN or STEP.
REQ-017 IDLE: start=1 and stop=0 -> RUN; else step=1 -> STEP; start has priority over step; stop=1 blocks start.
REQ-018 RUN: stop=1 -> IDLE with cycle_count preserved, so a later start resumes the count.
REQ-019 STEP: exactly one enabled cycle, then -> IDLE; step held high SHALL NOT re-trigger until it has been seen low for at least one cycle.
REQ-020 cycle_count SHALL increment by 1 on every edge with cpu_en=1, except the timeout edge (REQ-022).
REQ-021 Halt: isHalt=1 with cpu_en=1 -> DONE; that cycle counts; rpt_ret <= ret_val[7:0]; rpt_timeout <= 0; cpu_en=0 from the next cycle.
REQ-022 Timeout: cpu_en=1 and cycle_count==MAX_CYCLES and isHalt=0 -> DONE; no increment; rpt_timeout <= 1; rpt_ret <= 0.
REQ-023 isHalt and timeout in the same cycle: halt SHALL win.
REQ-024 stop and isHalt in the same RUN cycle: halt SHALL win.
REQ-025 DONE: rpt_valid=1; rpt_cycles, rpt_ret and rpt_timeout held stable until rpt_valid&rpt_ready.
REQ-026 On acceptance: -> IDLE, rpt_valid=0, cycle_count <= 0; start, stop and step are ignored while in DONE.
REQ-027 rpt_valid SHALL assert one cycle after the halt or timeout edge; rpt_ready high in that same cycle completes the handshake in one cycle.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state IDLE, cpu_en 0, cycle_count 0, rpt_valid 0, rpt_cycles 0, rpt_ret 0, rpt_timeout 0, step-rearm armed; this includes assertion mid-RUN and mid-handshake.
REQ-029 After rst_n deasserts, the first state change SHALL occur no earlier than the following rising edge.

Structure
REQ-030 The shared package SHALL hold the state enumeration (2-bit encoding), the default cycle budget 500000, and the report-record field widths (32, 8, 1).
REQ-031 One sub-module, run_cycle_ctr, SHALL hold the 32-bit counter with enable, clear and at-limit compare.

Verification
REQ-032 With MAX_CYCLES=20: start pulse, isHalt=1 on the 6th enabled cycle with ret_val=16'h002A -> rpt_valid, rpt_cycles=6, rpt_ret=8'h2A, rpt_timeout=0.
REQ-033 With MAX_CYCLES=20: start held, isHalt never asserted -> exactly 20 enabled cycles, then rpt_cycles=20, rpt_timeout=1.
REQ-034 Run 4 cycles, stop, idle 5 cycles, start, halt after 3 more enabled cycles -> cpu_en low during the pause; rpt_cycles=7.
REQ-035 Step held high for 10 cycles -> exactly 1 enabled cycle; release then step again -> cycle_count=2.
REQ-036 rpt_ready low for 8 cycles after a halt -> report fields stable throughout; on ready, state goes to IDLE and cycle_count=0.
REQ-037 rst_n low mid-RUN at cycle_count=9 -> all outputs 0 immediately without a clock edge; start afterwards counts from 0.
